// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with a one-cycle done or frame-error strobe.
// Optional build macro: UART_RECEIVER_MAJORITY_EN selects 2-of-3 majority voting
// at every sample point. Without it, each sample is the single synchronized value.
// Handshake: Done_o and FrameError_o are single-cycle strobes with no backpressure.
// Data_o is valid in the cycle Done_o is high and holds until the next good frame.
`timescale 1ns/1ps
module uart_receiver #(
  parameter int CLOCK_HZ = 10_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Rx_i,
  output logic [7:0] Data_o,
  output logic       Done_o,
  output logic       FrameError_o,
  output logic       Busy_o
);

  localparam int TICKS_PER_BIT = CLOCK_HZ / BAUD;
  localparam int HALF_BIT      = TICKS_PER_BIT / 2;
  localparam int CNT_W         = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(TICKS_PER_BIT - 1);

  // Too few ticks per bit leaves no room for a mid-bit sample point.
  generate
    if (TICKS_PER_BIT < 8) begin : g_bad_ratio
      $error("uart_receiver: TICKS_PER_BIT must be at least 8");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_data;
  logic             r_done;
  logic             r_ferr;
  logic             r_rx_meta;
  logic             r_rx_sync;
  logic             w_sample;

  // Two-flop synchronizer; idle-high line so both flops reset to 1.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= Rx_i;
      r_rx_sync <= r_rx_meta;
    end
  end

`ifdef UART_RECEIVER_MAJORITY_EN
  logic r_rx_h1;
  logic r_rx_h2;

  // Two cycles of synchronized history for the majority vote.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_rx_h1 <= 1'b1;
      r_rx_h2 <= 1'b1;
    end else begin
      r_rx_h1 <= r_rx_sync;
      r_rx_h2 <= r_rx_h1;
    end
  end

  assign w_sample = (r_rx_sync & r_rx_h1) | (r_rx_sync & r_rx_h2) | (r_rx_h1 & r_rx_h2);
`else
  assign w_sample = r_rx_sync;
`endif

  // Frame FSM: start qualification, data shifting, stop check and break wait.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_ferr <= 1'b0;
      case (r_state)
        IDLE: begin
          // Edge detection uses the raw synchronized line, not the vote.
          if (!r_rx_sync) begin
            r_state <= START;
            r_cnt   <= '0;
          end
        end
        START: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt <= '0;
            r_idx <= '0;
            // A line already back high at mid-start is a glitch.
            r_state <= w_sample ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt   <= '0;
            r_shift <= {w_sample, r_shift[7:1]};
            if (r_idx == 3'd7) begin
              r_state <= STOP;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt <= '0;
            if (w_sample) begin
              r_data  <= r_shift;
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= BREAK;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        BREAK: begin
          // A held-low line must release before a new start is accepted.
          if (r_rx_sync) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Data_o       = r_data;
  assign Done_o       = r_done;
  assign FrameError_o = r_ferr;
  assign Busy_o       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver at default parameters (86 ticks/bit, half bit 43).
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam int TPB  = 86;
  localparam int HALF = 43;

  // Clock and reset
  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       done;
  logic       ferr;
  logic       busy;

  always #50 clk = ~clk;

  uart_receiver #(
    .CLOCK_HZ(10_000_000),
    .BAUD    (115200)
  ) dut (
    .Clock       (clk),
    .Reset       (rst_n),
    .Rx_i        (rx),
    .Data_o      (data),
    .Done_o      (done),
    .FrameError_o(ferr),
    .Busy_o      (busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  logic [7:0] exp_q[$];
  logic [7:0] last_data = 8'h00;
  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int busy_cnt = 0;
  int done_cyc = 0;
  int prev_done_cyc = 0;
  int start_cyc = 0;
  logic busy_at_done = 1'b0;
  logic prev_strobe = 1'b0;

  // Monitor: pop expected bytes on Done_o and check strobe shape.
  always @(negedge clk) begin
    logic [7:0] exp_b;
    if (busy) busy_cnt++;
    if (done || ferr) begin
      n_vec++;
      if ((done && ferr) || prev_strobe) begin
        n_err++;
        $display("FAIL strobe_shape: done=%0b ferr=%0b prev_strobe=%0b, required one exclusive single-cycle pulse",
                 done, ferr, prev_strobe);
      end
    end
    if (ferr) ferr_cnt++;
    if (done) begin
      done_cnt++;
      prev_done_cyc = done_cyc;
      done_cyc = cyc;
      busy_at_done = busy;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: data=%02h with no byte expected", data);
      end else begin
        exp_b = exp_q.pop_front();
        if (data !== exp_b) begin
          n_err++;
          $display("FAIL rx_byte: got %02h expected %02h", data, exp_b);
        end
        last_data = exp_b;
      end
    end
    prev_strobe = done || ferr;
  end

  // Driver tasks: all drives land 1 time unit after a rising edge.
  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_bits);
    start_cyc = cyc;
    hold(1'b0, TPB);
    for (int i = 0; i < 8; i++) hold(b[i], TPB);
    hold(stop_v, TPB * stop_bits);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({data, done, ferr, busy} !== 11'b0) begin
      n_err++;
      $display("FAIL reset_outputs: data=%02h done=%0b ferr=%0b busy=%0b, required all zero", data, done, ferr, busy);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold(1'b1, 20);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_busy: busy=%0b required 0", busy);
    end
  endtask

  task automatic test_single_frame();
    int d0, f0;
    hold(1'b1, 100);
    d0 = done_cnt;
    f0 = ferr_cnt;
    busy_cnt = 0;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 2);
    hold(1'b1, 20);
    n_vec++;
    if (done_cnt - d0 != 1) begin
      n_err++;
      $display("FAIL single_done_count: got %0d required 1", done_cnt - d0);
    end
    n_vec++;
    if (done_cyc - start_cyc != 820) begin
      n_err++;
      $display("FAIL single_done_time: got t0+%0d required t0+818", done_cyc - start_cyc - 2);
    end
    n_vec++;
    if (busy_cnt != 817) begin
      n_err++;
      $display("FAIL single_busy_len: got %0d cycles required 817", busy_cnt);
    end
    n_vec++;
    if (busy_at_done !== 1'b0) begin
      n_err++;
      $display("FAIL busy_at_done: got %0b required 0", busy_at_done);
    end
    n_vec++;
    if (data !== 8'hA5 || ferr_cnt != f0) begin
      n_err++;
      $display("FAIL single_data: data=%02h ferr_pulses=%0d required A5 and 0", data, ferr_cnt - f0);
    end
  endtask

  task automatic test_back_to_back();
    int d0, f0;
    d0 = done_cnt;
    f0 = ferr_cnt;
    exp_q.push_back(8'h00);
    send_frame(8'h00, 1'b1, 1);
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b1, 1);
    hold(1'b1, 100);
    n_vec++;
    if (done_cnt - d0 != 2) begin
      n_err++;
      $display("FAIL b2b_done_count: got %0d required 2", done_cnt - d0);
    end
    n_vec++;
    if (done_cyc - prev_done_cyc != 860) begin
      n_err++;
      $display("FAIL b2b_spacing: got %0d required 860", done_cyc - prev_done_cyc);
    end
    n_vec++;
    if (data !== 8'hFF || ferr_cnt != f0) begin
      n_err++;
      $display("FAIL b2b_data: data=%02h ferr_pulses=%0d required FF and 0", data, ferr_cnt - f0);
    end
  endtask

  task automatic test_glitch();
    int d0, f0;
    d0 = done_cnt;
    f0 = ferr_cnt;
    busy_cnt = 0;
    hold(1'b0, 20);
    hold(1'b1, 200);
    n_vec++;
    if (busy_cnt != HALF) begin
      n_err++;
      $display("FAIL glitch_busy_len: got %0d required %0d", busy_cnt, HALF);
    end
    n_vec++;
    if (done_cnt != d0 || ferr_cnt != f0 || data !== last_data) begin
      n_err++;
      $display("FAIL glitch_quiet: done=%0d ferr=%0d data=%02h required 0 0 %02h",
               done_cnt - d0, ferr_cnt - f0, data, last_data);
    end
  endtask

  task automatic test_frame_error();
    int d0, f0;
    d0 = done_cnt;
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 1);
    hold(1'b0, 300);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL break_busy_low_line: busy=%0b required 1", busy);
    end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL break_busy_hold: busy=%0b required 1", busy);
    end
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL break_busy_release: busy=%0b required 0", busy);
    end
    @(posedge clk);
    #1;
    hold(1'b1, 1000);
    n_vec++;
    if (ferr_cnt - f0 != 1 || done_cnt != d0) begin
      n_err++;
      $display("FAIL break_strobes: ferr=%0d done=%0d required 1 0", ferr_cnt - f0, done_cnt - d0);
    end
    n_vec++;
    if (data !== last_data) begin
      n_err++;
      $display("FAIL break_data_kept: got %02h required %02h", data, last_data);
    end
  endtask

  task automatic test_mid_reset();
    int d0, f0;
    hold(1'b1, 50);
    d0 = done_cnt;
    f0 = ferr_cnt;
    // 0x0F partially sent: start, bits 0..2, then 40 cycles into bit 3.
    hold(1'b0, TPB);
    hold(1'b1, 3 * TPB + 40);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({data, done, ferr, busy} !== 11'b0) begin
      n_err++;
      $display("FAIL midreset_outputs: data=%02h done=%0b ferr=%0b busy=%0b, required all zero", data, done, ferr, busy);
    end
    last_data = 8'h00;
    @(posedge clk);
    #1;
    hold(1'b1, 500);
    n_vec++;
    if (done_cnt != d0 || ferr_cnt != f0) begin
      n_err++;
      $display("FAIL midreset_no_strobe: done=%0d ferr=%0d required 0 0", done_cnt - d0, ferr_cnt - f0);
    end
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 2);
    hold(1'b1, 20);
    n_vec++;
    if (done_cnt - d0 != 1 || data !== 8'h5A) begin
      n_err++;
      $display("FAIL midreset_recover: done=%0d data=%02h required 1 5A", done_cnt - d0, data);
    end
  endtask

  task automatic test_sample_glitch();
    int d0;
    logic [7:0] exp_b;
`ifdef UART_RECEIVER_MAJORITY_EN
    exp_b = 8'hFF;
`else
    exp_b = 8'hFE;
`endif
    d0 = done_cnt;
    exp_q.push_back(exp_b);
    hold(1'b0, TPB);
    hold(1'b1, HALF);
    hold(1'b0, 1);
    hold(1'b1, TPB - HALF - 1);
    hold(1'b1, 7 * TPB);
    hold(1'b1, 2 * TPB);
    hold(1'b1, 20);
    n_vec++;
    if (done_cnt - d0 != 1 || data !== exp_b) begin
      n_err++;
      $display("FAIL sample_glitch: done=%0d data=%02h required 1 %02h", done_cnt - d0, data, exp_b);
    end
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_mid_reset();
    test_sample_glitch();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover_expected: %0d bytes never received, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
